mul_pipe_hs: RTL
================

Name: mul_pipe_hs

Overview:
- Parametrised, fully pipelined integer multiplier with a valid/ready handshake on input and output.
- Accepts one operation per cycle and delivers results in order after STAGES cycles.
- Outputs full double-width product (hi/lo words) plus CR fields for each word.
- Sits in the fixed-point execution unit; carries a tag so issue logic can overlap back-to-back multiplies, stall on writeback backpressure, and flush on branch/exception.

Parameters:
- WIDTH, 32: operand width in bits; product is 2*WIDTH.
- STAGES, 4: pipeline depth, 1..WIDTH; equals latency in cycles.
- TAG_WIDTH, 5: width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous reset, active-low
- flush  in  1  synchronous kill of all in-flight operations
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid & in_ready
- in_uns  in  1  1 = unsigned operands, 0 = two's complement
- in_tag  in  TAG_WIDTH  tag returned with result
- a, b  in  WIDTH  operands
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_tag  out  TAG_WIDTH  tag of presented result
- res_hi, res_lo  out  WIDTH  upper/lower product word
- crf_hi, crf_lo  out  Cr_field  condition fields (lt, gt, eq, ov)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset_n=0, all stage valid bits, out_valid, out_tag, res_hi, res_lo, crf_hi and crf_lo are 0. Reset mid-operation discards all in-flight work; no result emerges after release.
- Pipeline control:
  - advance = ~out_valid | out_ready.
  - All stages shift together when advance=1 and hold entirely when advance=0 (global stall).
  - in_ready = advance. in_ready must not depend on in_valid.
- Latency/throughput:
  - An op accepted at cycle t shows out_valid at t+STAGES if no stall. Each stall cycle adds one.
  - Throughput is one op per cycle with out_ready held high.
- Arithmetic:
  - b is split into STAGES chunks of CH=ceil(WIDTH/STAGES) bits; the top chunk is zero/sign-extended per in_uns.
  - Stage k adds a*chunk_k << (k*CH) into a 2*WIDTH+1 accumulator.
  - Signed mode sign-extends a and treats the top chunk as signed.
  - in_uns and the tag travel with their op.
  - Result equals the exact 2*WIDTH product mod 2^(2*WIDTH).
- CR fields (per word, signed interpretation of that word):
  - lt = MSB set; eq = word zero; gt otherwise. Exactly one of lt/eq/gt is set.
  - crf_hi.ov = 0.
  - crf_lo.ov, signed mode: hi differs from the sign-extension of lo's MSB.
  - crf_lo.ov, unsigned mode: hi != 0.
- Output register: res/crf/out_tag hold stable while out_valid & ~out_ready.
- Flush:
  - Next edge clears all valid bits including out_valid.
  - Flush has priority over a simultaneous accept; an op offered in the flush cycle is dropped, with in_ready still reported.
  - Data registers need not be cleared.
- Simultaneous output handshake and input accept in the same cycle is legal and loses nothing.
- STAGES=1: purely registered single-cycle multiply with identical handshake.

Optional Feature:
- Macro: MUL_PIPE_SAT_EN.
- Defined:
  - Adds input port in_sat (1 bit, travels with the op).
  - When in_sat=1 and crf_lo.ov=1, res_lo is replaced by the saturated value: signed max 0x7FF..F or min 0x800..0 by true product sign; unsigned all-ones.
  - crf_lo.lt/gt/eq are recomputed on the saturated word; ov remains 1.
- Undefined: no in_sat port, no saturation logic, res_lo is always the raw low word.

Decomposition:
- Pu_types holds Cr_field and DWIDTH, plus a new mul_pipe_stage_t struct (valid, uns, sat, tag, a, b remainder, accumulator) and a function crf_of_word(word) returning lt/gt/eq.
- One sub-module is natural: mul_pipe_stage, a single partial-product-accumulate stage with stall enable, instantiated STAGES times via generate.

Test Plan (WIDTH=32, STAGES=4):
- Signed -1 * -1 → after 4 cycles res_hi=0x00000000, res_lo=0x00000001, crf_lo.gt=1, ov=0; unsigned 0xFFFFFFFF*0xFFFFFFFF → res_hi=0xFFFFFFFE, res_lo=0x00000001, crf_hi.lt=1, crf_lo.ov=1.
- Signed 0x7FFFFFFF*2 → res_hi=0, res_lo=0xFFFFFFFE, crf_lo.lt=1, ov=1; with MUL_PIPE_SAT_EN and in_sat=1 → res_lo=0x7FFFFFFF, crf_lo.gt=1, ov=1.
- Six back-to-back ops tags 0..5 with out_ready low for 3 cycles at the first out_valid → in_ready drops the same cycle, outputs hold stable, all six emerge in tag order, none lost or duplicated.
- flush asserted when tags 2..4 are in flight, with tag 5 offered the same cycle → only tags 0..1 ever appear; the next op accepted after flush emerges exactly 4 cycles later.
- reset_n pulsed low mid-stream → outputs 0 immediately (asynchronously); after release, no stale out_valid for 10 cycles.
- Random signed/unsigned operands including 0, 1, 0x80000000 and -1, 10k ops, random out_ready → results match the reference model product, CR fields and ov per rule.

Source files
------------

// File: rtl/mul_pipe_hs_pkg.sv
// mul_pipe_hs_pkg: condition-field type and helpers shared by the pipelined multiplier
package mul_pipe_hs_pkg;
  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
    logic ov;
  } cr_field_t;
  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction
  function automatic cr_field_t crf_of(input logic neg, input logic zero, input logic ov);
    return '{lt: neg, gt: ~neg & ~zero, eq: zero, ov: ov};
  endfunction
endpackage

// File: rtl/mul_pipe_stage.sv
// mul_pipe_stage: one partial-product-accumulate step with global stall and flush
module mul_pipe_stage
  import mul_pipe_hs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CH = 8,
  parameter int BW = 32,
  parameter int SW = 6,
  parameter int K = 0,
  parameter bit LAST = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             flush,
  input  logic             v_i,
  input  logic [SW-1:0]    side_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [BW-1:0]    b_i,
  input  logic [2*WIDTH:0] acc_i,
  output logic             v_o,
  output logic [SW-1:0]    side_o,
  output logic [WIDTH-1:0] a_o,
  output logic [BW-1:0]    b_o,
  output logic [2*WIDTH:0] acc_o
);
  localparam int D = 2 * WIDTH + 1;
  logic [D-1:0] a_ext, c_ext, acc_d;
  always_comb begin
    a_ext = {{(D - WIDTH){~side_i[0] & a_i[WIDTH-1]}}, a_i};
    c_ext = {{(D - CH){LAST & ~side_i[0] & b_i[CH-1]}}, b_i[CH-1:0]};
    acc_d = acc_i + ((a_ext * c_ext) << (K * CH));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v_o    <= 1'b0;
      side_o <= '0;
      a_o    <= '0;
      b_o    <= '0;
      acc_o  <= '0;
    end else begin
      v_o <= ~flush & (en ? v_i : v_o);
      if (en) begin
        side_o <= side_i;
        a_o    <= a_i;
        b_o    <= b_i >> CH;
        acc_o  <= acc_d;
      end
    end
endmodule

// File: rtl/mul_pipe_hs.sv
// mul_pipe_hs: valid/ready pipelined multiplier with CR fields; MUL_PIPE_SAT_EN adds in_sat saturation
module mul_pipe_hs
  import mul_pipe_hs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STAGES = 4,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_uns,
`ifdef MUL_PIPE_SAT_EN
  input  logic                 in_sat,
`endif
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [WIDTH-1:0]     res_hi,
  output logic [WIDTH-1:0]     res_lo,
  output cr_field_t            crf_hi,
  output cr_field_t            crf_lo
);
  localparam int CH = ceil_div(WIDTH, STAGES);
  localparam int BW = STAGES * CH;
`ifdef MUL_PIPE_SAT_EN
  localparam int SW = TAG_WIDTH + 2;
`else
  localparam int SW = TAG_WIDTH + 1;
`endif
  logic                 advance, ov, unused;
  logic [STAGES:0]      v;
  logic [SW-1:0]        side [STAGES+1];
  logic [WIDTH-1:0]     op_a [STAGES+1];
  logic [BW-1:0]        op_b [STAGES+1];
  logic [2*WIDTH:0]     acc  [STAGES+1];
  logic [WIDTH-1:0]     lo_raw;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  assign v[0]     = in_valid;
`ifdef MUL_PIPE_SAT_EN
  assign side[0]  = {in_tag, in_sat, in_uns};
`else
  assign side[0]  = {in_tag, in_uns};
`endif
  assign op_a[0]  = a;
  assign op_b[0]  = in_uns ? BW'(b) : BW'($signed(b));
  assign acc[0]   = '0;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    mul_pipe_stage #(
      .WIDTH(WIDTH), .CH(CH), .BW(BW), .SW(SW), .K(k), .LAST(k == STAGES - 1)
    ) u_stage (
      .clk(clk), .reset_n(reset_n), .en(advance), .flush(flush),
      .v_i(v[k]), .side_i(side[k]), .a_i(op_a[k]), .b_i(op_b[k]), .acc_i(acc[k]),
      .v_o(v[k+1]), .side_o(side[k+1]), .a_o(op_a[k+1]), .b_o(op_b[k+1]), .acc_o(acc[k+1])
    );
  end
  assign out_valid = v[STAGES];
  assign out_tag   = side[STAGES][SW-1 -: TAG_WIDTH];
  assign res_hi    = acc[STAGES][2*WIDTH-1:WIDTH];
  assign lo_raw    = acc[STAGES][WIDTH-1:0];
  assign ov        = side[STAGES][0] ? |res_hi : res_hi != {WIDTH{lo_raw[WIDTH-1]}};
`ifdef MUL_PIPE_SAT_EN
  logic [WIDTH-1:0] lo_sat;
  assign lo_sat = side[STAGES][0] ? '1 : {res_hi[WIDTH-1], {(WIDTH - 1){~res_hi[WIDTH-1]}}};
  assign res_lo = side[STAGES][1] & ov ? lo_sat : lo_raw;
`else
  assign res_lo = lo_raw;
`endif
  assign crf_hi = out_valid ? crf_of(res_hi[WIDTH-1], ~|res_hi, 1'b0) : '0;
  assign crf_lo = out_valid ? crf_of(res_lo[WIDTH-1], ~|res_lo, ov) : '0;
  assign unused = ^{op_a[STAGES], op_b[STAGES], acc[STAGES][2*WIDTH]};
endmodule
